nmr_bstrm_mch: RTL and testbench
================================

# nmr_bstrm_mch

Multi-channel, loop-capable successor to the single-pulse NMR bitstream block. It fetches segment entries from on-chip SRAM and drives a CH_NUM-bit output pattern for the programmed duration of each entry. The next entry is prefetched while the current one plays, so consecutive segments are gapless. Hardware loops repeat a block of entries without the host rewriting SRAM. It sits between the host-written sequence RAM and the NMR TX/RX gate lines.

## Interface
- CH_NUM, 8: output channels; 1..32.
- DUR_WIDTH, 32: segment duration width, in CLK cycles.
- LOOP_WIDTH, 16: loop count width.
- SRAM_ADDR_WIDTH, 8: sequence RAM address width.
- SRAM_DAT_WIDTH, 128: sequence RAM data width.
- SRAM_BYTEEN_WIDTH, 16: sequence RAM byte-enable width.
- IDLE_PATTERN, 0: OUT value while idle, width CH_NUM.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- START  in  1  level; sampled only in IDLE.
- ABORT  in  1  synchronous stop request.
- DONE  out  1  one-cycle pulse on normal completion.
- BUSY  out  1  high from the cycle after START is accepted until return to IDLE.
- ERR  out  1  sticky; set when any entry has DUR<3; cleared when the next START is accepted.
- SRAM_ADDR  out  SRAM_ADDR_WIDTH  registered read address.
- SRAM_CS  out  1  equals BUSY.
- SRAM_CLKEN  out  1  constant 1.
- SRAM_WR  out  1  constant 0.
- SRAM_RD_DAT  in  SRAM_DAT_WIDTH  read data; fixed latency of 2 cycles.
- SRAM_WR_DAT  out  SRAM_DAT_WIDTH  constant 0.
- SRAM_BYTEEN  out  SRAM_BYTEEN_WIDTH  all ones.
- OUT  out  CH_NUM  registered channel pattern.

## Operation
- Entry fields:
  - [CH_NUM-1:0] PAT
  - [32+DUR_WIDTH-1:32] DUR
  - [64+LOOP_WIDTH-1:64] LOOP
  - [80] LB (loop begin)
  - [81] LE (loop end)
  - [82] LAST
  - All other bits are ignored.
- States: IDLE, FETCH, WAIT, PLAY.
  - IDLE: when START=1, go to FETCH, set SRAM_ADDR=0, clear ERR, set BUSY.
  - FETCH → WAIT: one cycle each, covering SRAM latency.
  - WAIT → PLAY: load the entry. OUT<=PAT and start the segment counter.
  - PLAY: hold OUT for eff_DUR cycles, where eff_DUR=max(DUR,3). At segment end, load the buffered next entry directly, or finish if the current entry has LAST set.
- Prefetch: on the edge that loads a segment, SRAM_ADDR<=next_addr. Data is captured in the segment's third cycle.
- next_addr, decided at segment load:
  - LE=1 and loop_cnt>1: loop_cnt<=loop_cnt-1, next_addr=loop_start, and set the jumped flag.
  - Otherwise: next_addr=addr+1, wrapping modulo 2^SRAM_ADDR_WIDTH with no error.
- Loop begin (LB=1, reached by fall-through, i.e. jumped=0): loop_start<=addr and loop_cnt<=LOOP. LOOP=0 is treated as 1.
- Loop begin reached by jump: LB is ignored.
- Loop semantics:
  - The loop body executes LOOP times.
  - LB and LE on the same entry repeats that entry LOOP times.
  - Single nesting level only: a new fall-through LB overwrites loop state.
- LAST=1: no further fetch is issued.
  - On the edge after the segment ends: OUT<=IDLE_PATTERN, DONE<=1 for one cycle, state goes to IDLE, BUSY goes to 0.
  - LAST overrides LE.
- DUR<3 (including 0): segment lasts 3 cycles and ERR is set.
- ABORT=1 in any non-IDLE state: on the next edge, OUT<=IDLE_PATTERN, state goes to IDLE, BUSY goes to 0. DONE is not pulsed. ABORT has priority over segment end.
- START while BUSY: ignored.
- Reset asserted (RST=0) at any time, including mid-sequence, immediately forces:
  - OUT=IDLE_PATTERN
  - DONE=0, BUSY=0, ERR=0
  - SRAM_CS=0, SRAM_ADDR=0
  - state=IDLE, loop state cleared

## Timing
- Cycle numbering: cycle 0 is the cycle in which START is sampled high in IDLE.
- Address 0 is presented in cycle 1. Data is valid in cycle 3. OUT shows entry 0's PAT from cycle 4.
- Each segment holds OUT for exactly eff_DUR cycles. The next PAT appears in the following cycle with no gap, including across loop jumps.
- DONE rises in the same cycle that OUT returns to IDLE_PATTERN.
- BUSY falls in that same cycle.
- A new START is accepted from the cycle after DONE.

## Test plan
- Basic sequence: entry0 {PAT=0x01, DUR=5}, entry1 {PAT=0x02, DUR=3, LAST}; START in cycle 0 → OUT=0x01 in cycles 4–8, 0x02 in cycles 9–11, IDLE_PATTERN and DONE=1 in cycle 12, ERR=0.
- Loop: entry0 {0x01, DUR=4, LB, LOOP=3}, entry1 {0x02, DUR=4, LE}, entry2 {0x00, DUR=3, LAST} → pattern 0x01,0x02 repeated 3 times over cycles 4–27, 0x00 in cycles 28–30, DONE in cycle 31.
- Short duration: entry0 {0xFF, DUR=0, LAST} → OUT=0xFF in cycles 4–6, DONE in cycle 7, ERR=1 until the next START.
- Abort: 10-entry sequence with DUR=100; ABORT in cycle 50 → OUT=IDLE_PATTERN and BUSY=0 in cycle 51, DONE never pulses; a following START runs from address 0.
- Reset mid-sequence: drop RST in cycle 20 → outputs reach reset values asynchronously, with no glitch back to PAT after release; START after release restarts with the same 4-cycle latency.
- Address wrap: SRAM_ADDR_WIDTH=2, entry3 {DUR=3} with no LAST, entry0 {LAST} → address sequence 0,1,2,3,0, after which the block ends with DONE; START pulses while BUSY are ignored.

Source files
------------

// File: rtl/nmr_bstrm_mch.sv
// Multi-channel NMR bitstream sequencer: plays SRAM-resident pattern segments
// gaplessly with next-entry prefetch and single-level hardware loops.
module nmr_bstrm_mch #(
    parameter int unsigned       CH_NUM            = 8,
    parameter int unsigned       DUR_WIDTH         = 32,
    parameter int unsigned       LOOP_WIDTH        = 16,
    parameter int unsigned       SRAM_ADDR_WIDTH   = 8,
    parameter int unsigned       SRAM_DAT_WIDTH    = 128,
    parameter int unsigned       SRAM_BYTEEN_WIDTH = 16,
    parameter logic [CH_NUM-1:0] IDLE_PATTERN      = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         START,
    input  logic                         ABORT,
    output logic                         DONE,
    output logic                         BUSY,
    output logic                         ERR,
    output logic [SRAM_ADDR_WIDTH-1:0]   SRAM_ADDR,
    output logic                         SRAM_CS,
    output logic                         SRAM_CLKEN,
    output logic                         SRAM_WR,
    input  logic [SRAM_DAT_WIDTH-1:0]    SRAM_RD_DAT,
    output logic [SRAM_DAT_WIDTH-1:0]    SRAM_WR_DAT,
    output logic [SRAM_BYTEEN_WIDTH-1:0] SRAM_BYTEEN,
    output logic [CH_NUM-1:0]            OUT
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_PLAY  = 2'd3;

    logic [1:0]                  state_q, state_d;
    logic                        wcnt_q, wcnt_d;
    logic [SRAM_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [CH_NUM-1:0]           out_q, out_d;
    logic                        done_q, done_d;
    logic                        busy_q, busy_d;
    logic                        err_q, err_d;
    logic [DUR_WIDTH-1:0]        el_q, el_d;
    logic [DUR_WIDTH-1:0]        dur_q, dur_d;
    logic                        last_q, last_d;
    logic [SRAM_DAT_WIDTH-1:0]   nbuf_q, nbuf_d;
    logic [SRAM_ADDR_WIDTH-1:0]  lstart_q, lstart_d;
    logic [LOOP_WIDTH-1:0]       lcnt_q, lcnt_d;
    logic                        jumped_q, jumped_d;

    logic [SRAM_DAT_WIDTH-1:0]   ent;
    logic [CH_NUM-1:0]           e_pat;
    logic [DUR_WIDTH-1:0]        e_dur;
    logic [DUR_WIDTH-1:0]        e_dm1;
    logic [LOOP_WIDTH-1:0]       e_loop;
    logic                        e_lb, e_le, e_last, e_short;
    logic                        lp_fresh, take_jump, do_load, cap_cycle;
    logic [LOOP_WIDTH-1:0]       lc;
    logic [SRAM_ADDR_WIDTH-1:0]  ls, nxt_addr;
    logic                        unused_ent;

    // Third segment cycle: prefetched data is valid on the bus right now, so a
    // 3-cycle segment must load its successor straight from SRAM_RD_DAT.
    assign cap_cycle = (state_q == S_PLAY) && (el_q == DUR_WIDTH'(2));

    always_comb begin
        ent       = (state_q == S_PLAY && !cap_cycle) ? nbuf_q : SRAM_RD_DAT;
        e_pat     = ent[CH_NUM-1:0];
        e_dur     = ent[32 +: DUR_WIDTH];
        e_loop    = ent[64 +: LOOP_WIDTH];
        e_lb      = ent[80];
        e_le      = ent[81];
        e_last    = ent[82];
        e_short   = e_dur < DUR_WIDTH'(3);
        e_dm1     = e_short ? DUR_WIDTH'(2) : e_dur - DUR_WIDTH'(1);
        lp_fresh  = e_lb && !jumped_q;
        lc        = lp_fresh ? ((e_loop == '0) ? LOOP_WIDTH'(1) : e_loop) : lcnt_q;
        ls        = lp_fresh ? addr_q : lstart_q;
        take_jump = e_le && !e_last && (lc > LOOP_WIDTH'(1));
        nxt_addr  = take_jump ? ls : addr_q + SRAM_ADDR_WIDTH'(1);
    end

    assign unused_ent = ^ent;

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        addr_d   = addr_q;
        out_d    = out_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        err_d    = err_q;
        el_d     = el_q;
        dur_d    = dur_q;
        last_d   = last_q;
        nbuf_d   = nbuf_q;
        lstart_d = lstart_q;
        lcnt_d   = lcnt_q;
        jumped_d = jumped_q;
        do_load  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START && !done_q) begin
                    state_d  = S_FETCH;
                    addr_d   = '0;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                    jumped_d = 1'b0;
                    lcnt_d   = '0;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
                wcnt_d  = 1'b0;
            end
            S_WAIT: begin
                if (wcnt_q) do_load = 1'b1;
                else        wcnt_d  = 1'b1;
            end
            default: begin
                el_d = el_q + DUR_WIDTH'(1);
                if (cap_cycle) nbuf_d = SRAM_RD_DAT;
                if (el_q == dur_q) begin
                    if (last_q) begin
                        state_d = S_IDLE;
                        out_d   = IDLE_PATTERN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        do_load = 1'b1;
                    end
                end
            end
        endcase

        if (do_load) begin
            state_d  = S_PLAY;
            out_d    = e_pat;
            el_d     = '0;
            dur_d    = e_dm1;
            last_d   = e_last;
            err_d    = err_q | e_short;
            lstart_d = ls;
            lcnt_d   = take_jump ? lc - LOOP_WIDTH'(1) : lc;
            jumped_d = take_jump;
            if (!e_last) addr_d = nxt_addr;
        end

        if (ABORT && state_q != S_IDLE) begin
            state_d = S_IDLE;
            out_d   = IDLE_PATTERN;
            done_d  = 1'b0;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            wcnt_q   <= 1'b0;
            addr_q   <= '0;
            out_q    <= IDLE_PATTERN;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            el_q     <= '0;
            dur_q    <= '0;
            last_q   <= 1'b0;
            nbuf_q   <= '0;
            lstart_q <= '0;
            lcnt_q   <= '0;
            jumped_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            addr_q   <= addr_d;
            out_q    <= out_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            el_q     <= el_d;
            dur_q    <= dur_d;
            last_q   <= last_d;
            nbuf_q   <= nbuf_d;
            lstart_q <= lstart_d;
            lcnt_q   <= lcnt_d;
            jumped_q <= jumped_d;
        end
    end

    assign DONE        = done_q;
    assign BUSY        = busy_q;
    assign ERR         = err_q;
    assign OUT         = out_q;
    assign SRAM_ADDR   = addr_q;
    assign SRAM_CS     = busy_q;
    assign SRAM_CLKEN  = 1'b1;
    assign SRAM_WR     = 1'b0;
    assign SRAM_WR_DAT = '0;
    assign SRAM_BYTEEN = '1;

endmodule

// File: tb/tb_nmr_bstrm_mch.sv
// Directed bench for nmr_bstrm_mch: default build plus a 2-bit-address build
// for the wrap scenario, each with a 2-cycle-latency SRAM model.
module tb_nmr_bstrm_mch;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         start, abort, start2, abort2;
    logic         done, busy, err, cs, clken, wr;
    logic         done2, busy2, err2, cs2, clken2, wr2;
    logic [7:0]   addr, dout, dout2;
    logic [1:0]   addr2;
    logic [127:0] rd_dat, wr_dat, rd_dat2, wr_dat2;
    logic [15:0]  byteen, byteen2;

    logic [127:0] mem  [256];
    logic [127:0] mem2 [4];
    logic [127:0] rd1, rd2, rd1b, rd2b;

    always @(posedge clk) begin
        rd1  <= mem[addr];
        rd2  <= rd1;
        rd1b <= mem2[addr2];
        rd2b <= rd1b;
    end
    assign rd_dat  = rd2;
    assign rd_dat2 = rd2b;

    nmr_bstrm_mch dut (
        .CLK(clk), .RST(rst_n), .START(start), .ABORT(abort),
        .DONE(done), .BUSY(busy), .ERR(err),
        .SRAM_ADDR(addr), .SRAM_CS(cs), .SRAM_CLKEN(clken), .SRAM_WR(wr),
        .SRAM_RD_DAT(rd_dat), .SRAM_WR_DAT(wr_dat), .SRAM_BYTEEN(byteen),
        .OUT(dout)
    );

    nmr_bstrm_mch #(.SRAM_ADDR_WIDTH(2)) dut_w (
        .CLK(clk), .RST(rst_n), .START(start2), .ABORT(abort2),
        .DONE(done2), .BUSY(busy2), .ERR(err2),
        .SRAM_ADDR(addr2), .SRAM_CS(cs2), .SRAM_CLKEN(clken2), .SRAM_WR(wr2),
        .SRAM_RD_DAT(rd_dat2), .SRAM_WR_DAT(wr_dat2), .SRAM_BYTEEN(byteen2),
        .OUT(dout2)
    );

    function automatic logic [127:0] ent(input logic [7:0] pat, input logic [31:0] dur,
                                         input logic [15:0] loop, input logic lb,
                                         input logic le, input logic last);
        logic [127:0] e;
        e          = '0;
        e[7:0]     = pat;
        e[63:32]   = dur;
        e[79:64]   = loop;
        e[80]      = lb;
        e[81]      = le;
        e[82]      = last;
        e[127:120] = 8'hA5;
        e[31:24]   = 8'h5A;
        return e;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    // START is sampled on the edge after it is raised; returns mid-cycle 1.
    task automatic kick(input bit wrap_dut);
        @(negedge clk);
        if (wrap_dut) start2 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (dout !== 8'h00)   begin errors++; $display("FAIL reset_out got=%h exp=00", dout); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (cs !== 1'b0)      begin errors++; $display("FAIL reset_cs got=%b exp=0", cs); end
        checks++; if (addr !== 8'h00)   begin errors++; $display("FAIL reset_addr got=%h exp=00", addr); end
        checks++; if (clken !== 1'b1)   begin errors++; $display("FAIL reset_clken got=%b exp=1", clken); end
        checks++; if (wr !== 1'b0)      begin errors++; $display("FAIL reset_wr got=%b exp=0", wr); end
        checks++; if (wr_dat !== '0)    begin errors++; $display("FAIL reset_wrdat got=%h exp=0", wr_dat); end
        checks++; if (byteen !== 16'hFFFF) begin errors++; $display("FAIL reset_byteen got=%h exp=ffff", byteen); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] eo;
        clear_mem();
        mem[0] = ent(8'h01, 5, 0, 0, 0, 0);
        mem[1] = ent(8'h02, 3, 0, 0, 0, 1);
        kick(0);
        for (int c = 1; c <= 13; c++) begin
            if (c > 1) @(negedge clk);
            eo = (c >= 4 && c <= 8) ? 8'h01 : (c >= 9 && c <= 11) ? 8'h02 : 8'h00;
            checks++; if (dout !== eo) begin errors++; $display("FAIL basic_out cyc=%0d got=%h exp=%h", c, dout, eo); end
            checks++; if (done !== (c == 12)) begin errors++; $display("FAIL basic_done cyc=%0d got=%b exp=%b", c, done, c == 12); end
            checks++; if (busy !== (c <= 11)) begin errors++; $display("FAIL basic_busy cyc=%0d got=%b exp=%b", c, busy, c <= 11); end
            if (c == 1) begin checks++; if (addr !== 8'd0) begin errors++; $display("FAIL basic_addr0 got=%0d exp=0", addr); end end
            if (c == 4) begin checks++; if (addr !== 8'd1) begin errors++; $display("FAIL basic_addr1 got=%0d exp=1", addr); end end
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err got=%b exp=0", err); end
    endtask

    task automatic test_loop();
        logic [7:0] eo;
        clear_mem();
        mem[0] = ent(8'h01, 4, 3, 1, 0, 0);
        mem[1] = ent(8'h02, 4, 0, 0, 1, 0);
        mem[2] = ent(8'h04, 3, 0, 0, 0, 1);
        kick(0);
        for (int c = 1; c <= 33; c++) begin
            if (c > 1) @(negedge clk);
            if (c >= 4 && c <= 27)       eo = (((c - 4) / 4) % 2 == 0) ? 8'h01 : 8'h02;
            else if (c >= 28 && c <= 30) eo = 8'h04;
            else                         eo = 8'h00;
            checks++; if (dout !== eo) begin errors++; $display("FAIL loop_out cyc=%0d got=%h exp=%h", c, dout, eo); end
            checks++; if (done !== (c == 31)) begin errors++; $display("FAIL loop_done cyc=%0d got=%b exp=%b", c, done, c == 31); end
            if (c == 8) begin checks++; if (addr !== 8'd0) begin errors++; $display("FAIL loop_jump_addr got=%0d exp=0", addr); end end
            if (c == 24) begin checks++; if (addr !== 8'd2) begin errors++; $display("FAIL loop_exit_addr got=%0d exp=2", addr); end end
        end
    endtask

    task automatic test_short();
        logic [7:0] eo;
        clear_mem();
        mem[0] = ent(8'hFF, 0, 0, 0, 0, 1);
        kick(0);
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) @(negedge clk);
            eo = (c >= 4 && c <= 6) ? 8'hFF : 8'h00;
            checks++; if (dout !== eo) begin errors++; $display("FAIL short_out cyc=%0d got=%h exp=%h", c, dout, eo); end
            checks++; if (done !== (c == 7)) begin errors++; $display("FAIL short_done cyc=%0d got=%b exp=%b", c, done, c == 7); end
            checks++; if (err !== (c >= 4)) begin errors++; $display("FAIL short_err cyc=%0d got=%b exp=%b", c, err, c >= 4); end
        end
    endtask

    task automatic test_abort();
        clear_mem();
        for (int i = 0; i < 10; i++) mem[i] = ent(8'(i + 1), 100, 0, 0, 0, i == 9);
        kick(0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_err_clear got=%b exp=0", err); end
        for (int c = 2; c <= 50; c++) begin
            @(negedge clk);
            if (c == 50) begin checks++; if (dout !== 8'h01) begin errors++; $display("FAIL abort_pre_out got=%h exp=01", dout); end end
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL abort_out got=%h exp=00", dout); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (cs !== 1'b0)    begin errors++; $display("FAIL abort_cs got=%b exp=0", cs); end
        for (int c = 51; c <= 58; c++) begin
            if (c > 51) @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_nodone cyc=%0d got=%b exp=0", c, done); end
        end
        kick(0);
        checks++; if (addr !== 8'd0) begin errors++; $display("FAIL abort_restart_addr got=%0d exp=0", addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_restart_busy got=%b exp=1", busy); end
        repeat (3) @(negedge clk);
        checks++; if (dout !== 8'h01) begin errors++; $display("FAIL abort_restart_out got=%h exp=01", dout); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        clear_mem();
        mem[0] = ent(8'h11, 2, 0, 0, 0, 0);
        mem[1] = ent(8'h22, 100, 0, 0, 0, 1);
        kick(0);
        repeat (19) @(negedge clk);
        checks++; if (dout !== 8'h22) begin errors++; $display("FAIL rstmid_pre_out got=%h exp=22", dout); end
        checks++; if (err !== 1'b1)   begin errors++; $display("FAIL rstmid_pre_err got=%b exp=1", err); end
        rst_n = 1'b0;
        #1;
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rstmid_out got=%h exp=00", dout); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (err !== 1'b0)   begin errors++; $display("FAIL rstmid_err got=%b exp=0", err); end
        checks++; if (cs !== 1'b0)    begin errors++; $display("FAIL rstmid_cs got=%b exp=0", cs); end
        checks++; if (addr !== 8'd0)  begin errors++; $display("FAIL rstmid_addr got=%0d exp=0", addr); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL rstmid_done got=%b exp=0", done); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rstmid_post_out k=%0d got=%h exp=00", k, dout); end
            checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rstmid_post_busy k=%0d got=%b exp=0", k, busy); end
        end
        kick(0);
        repeat (2) @(negedge clk);
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rstmid_lat3 got=%h exp=00", dout); end
        @(negedge clk);
        checks++; if (dout !== 8'h11) begin errors++; $display("FAIL rstmid_lat4 got=%h exp=11", dout); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [7:0] eo;
        logic [1:0] ea;
        mem2[0] = ent(8'h01, 3, 0, 0, 0, 0);
        mem2[1] = ent(8'h02, 3, 0, 0, 0, 0);
        mem2[2] = ent(8'h03, 3, 0, 0, 0, 0);
        mem2[3] = ent(8'h04, 3, 0, 0, 0, 0);
        kick(1);
        for (int c = 1; c <= 22; c++) begin
            if (c > 1) @(negedge clk);
            start2 = (c == 8 || c == 14);
            if (c == 5) mem2[0] = ent(8'h05, 3, 0, 0, 0, 1);
            if (c >= 4 && c <= 18) eo = 8'((c - 4) / 3 + 1);
            else                   eo = 8'h00;
            checks++; if (dout2 !== eo) begin errors++; $display("FAIL wrap_out cyc=%0d got=%h exp=%h", c, dout2, eo); end
            checks++; if (done2 !== (c == 19)) begin errors++; $display("FAIL wrap_done cyc=%0d got=%b exp=%b", c, done2, c == 19); end
            checks++; if (busy2 !== (c <= 18)) begin errors++; $display("FAIL wrap_busy cyc=%0d got=%b exp=%b", c, busy2, c <= 18); end
            if (c == 1 || c == 4 || c == 7 || c == 10 || c == 13 || c == 16) begin
                ea = (c == 1 || c >= 13) ? 2'd0 : 2'((c - 1) / 3);
                checks++; if (addr2 !== ea) begin errors++; $display("FAIL wrap_addr cyc=%0d got=%0d exp=%0d", c, addr2, ea); end
            end
        end
        start2 = 1'b0;
        checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL wrap_err got=%b exp=0", err2); end
    endtask

    initial begin
        start  = 1'b0;
        abort  = 1'b0;
        start2 = 1'b0;
        abort2 = 1'b0;
        clear_mem();
        for (int i = 0; i < 4; i++) mem2[i] = '0;
        test_reset();
        test_basic();
        test_loop();
        test_short();
        test_abort();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
